// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with a valid/ready handshake, flush and bubble counting.
// Optional load-use hazard detection is enabled by defining ID_EX_LOAD_USE_HAZARD_EN.
// A bubble (out_valid=0) always carries cleared control bits, so it behaves as a NOP.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 7,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned ALUOP_W = 6,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic               reg_dst,
  input  logic               alu_src,
  input  logic               branch,
  input  logic               mem_write,
  input  logic               reg_write,
  input  logic               mem_to_reg,
  input  logic [PC_W-1:0]    pc_next,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  sign_extend,
  input  logic [RADDR_W-1:0] reg1,
  input  logic [RADDR_W-1:0] reg2,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  output logic [ALUOP_W-1:0] alu_op_reg,
  output logic               reg_dst_reg,
  output logic               alu_src_reg,
  output logic               branch_reg,
  output logic               mem_write_reg,
  output logic               reg_write_reg,
  output logic               mem_to_reg_reg,
  output logic [PC_W-1:0]    pc_next_reg,
  output logic [DATA_W-1:0]  data1_reg,
  output logic [DATA_W-1:0]  data2_reg,
  output logic [DATA_W-1:0]  sign_extend_reg,
  output logic [RADDR_W-1:0] reg1_reg,
  output logic [RADDR_W-1:0] reg2_reg,
  output logic [RADDR_W-1:0] rs_reg,
  output logic [RADDR_W-1:0] rt_reg,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic               hazard_stall
);

  logic load;
  logic drain;
  logic valid_d;

`ifdef ID_EX_LOAD_USE_HAZARD_EN
  // Held load whose destination feeds the incoming instruction: stall decode one bubble.
  always_comb begin
    hazard_stall = out_valid & mem_to_reg_reg & reg_write_reg & (rt_reg != '0) &
                   ((rt_reg == rs) | (rt_reg == rt));
  end
`else
  assign hazard_stall = 1'b0;
`endif

  // Handshake decode and next-state valid; flush overrides everything.
  always_comb begin
    in_ready = (~out_valid | out_ready) & ~hazard_stall;
    load     = in_valid & in_ready;
    drain    = out_valid & out_ready & ~load;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end else begin
      valid_d = out_valid;
    end
  end

  // Valid and control fields: captured on load, cleared whenever the stage goes empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      alu_op_reg     <= '0;
      reg_dst_reg    <= 1'b0;
      alu_src_reg    <= 1'b0;
      branch_reg     <= 1'b0;
      mem_write_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
    end else begin
      out_valid <= valid_d;
      if (flush || drain) begin
        alu_op_reg     <= '0;
        branch_reg     <= 1'b0;
        mem_write_reg  <= 1'b0;
        reg_write_reg  <= 1'b0;
        mem_to_reg_reg <= 1'b0;
      end else if (load) begin
        alu_op_reg     <= alu_op;
        reg_dst_reg    <= reg_dst;
        alu_src_reg    <= alu_src;
        branch_reg     <= branch;
        mem_write_reg  <= mem_write;
        reg_write_reg  <= reg_write;
        mem_to_reg_reg <= mem_to_reg;
      end
    end
  end

  // Data and specifier fields only change on an unflushed load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_next_reg     <= '0;
      data1_reg       <= '0;
      data2_reg       <= '0;
      sign_extend_reg <= '0;
      reg1_reg        <= '0;
      reg2_reg        <= '0;
      rs_reg          <= '0;
      rt_reg          <= '0;
    end else if (load && !flush) begin
      pc_next_reg     <= pc_next;
      data1_reg       <= data1;
      data2_reg       <= data2;
      sign_extend_reg <= sign_extend;
      reg1_reg        <= reg1;
      reg2_reg        <= reg2;
      rs_reg          <= rs;
      rt_reg          <= rt;
    end
  end

  // Saturating count of edges that leave the stage empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!valid_d && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios followed by random traffic,
// all compared against an instruction-level reference model. Honors ID_EX_LOAD_USE_HAZARD_EN.
module tb_id_ex_pipe_reg;

  localparam int unsigned CntMax = 15;

  typedef struct packed {
    logic [5:0]  alu_op;
    logic        reg_dst;
    logic        alu_src;
    logic        branch;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [6:0]  pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] se;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, flush, out_ready, out_valid, hazard_stall;
  logic [3:0] bubble_cnt;
  ins_t in_s, out_s, m_s;

  logic [5:0]  alu_op_reg;
  logic        reg_dst_reg, alu_src_reg, branch_reg, mem_write_reg, reg_write_reg, mem_to_reg_reg;
  logic [6:0]  pc_next_reg;
  logic [31:0] data1_reg, data2_reg, sign_extend_reg;
  logic [4:0]  reg1_reg, reg2_reg, rs_reg, rt_reg;

  logic m_valid;
  int   m_bub;
  int   total = 0;
  int   bad = 0;
  logic last_rdy, last_hz;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(
    .DATA_W (32),
    .PC_W   (7),
    .RADDR_W(5),
    .ALUOP_W(6),
    .CNT_W  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .alu_op         (in_s.alu_op),
    .reg_dst        (in_s.reg_dst),
    .alu_src        (in_s.alu_src),
    .branch         (in_s.branch),
    .mem_write      (in_s.mem_write),
    .reg_write      (in_s.reg_write),
    .mem_to_reg     (in_s.mem_to_reg),
    .pc_next        (in_s.pc),
    .data1          (in_s.d1),
    .data2          (in_s.d2),
    .sign_extend    (in_s.se),
    .reg1           (in_s.r1),
    .reg2           (in_s.r2),
    .rs             (in_s.rs),
    .rt             (in_s.rt),
    .alu_op_reg     (alu_op_reg),
    .reg_dst_reg    (reg_dst_reg),
    .alu_src_reg    (alu_src_reg),
    .branch_reg     (branch_reg),
    .mem_write_reg  (mem_write_reg),
    .reg_write_reg  (reg_write_reg),
    .mem_to_reg_reg (mem_to_reg_reg),
    .pc_next_reg    (pc_next_reg),
    .data1_reg      (data1_reg),
    .data2_reg      (data2_reg),
    .sign_extend_reg(sign_extend_reg),
    .reg1_reg       (reg1_reg),
    .reg2_reg       (reg2_reg),
    .rs_reg         (rs_reg),
    .rt_reg         (rt_reg),
    .bubble_cnt     (bubble_cnt),
    .hazard_stall   (hazard_stall)
  );

  assign out_s = {alu_op_reg, reg_dst_reg, alu_src_reg, branch_reg, mem_write_reg,
                  reg_write_reg, mem_to_reg_reg, pc_next_reg, data1_reg, data2_reg,
                  sign_extend_reg, reg1_reg, reg2_reg, rs_reg, rt_reg};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hazard();
`ifdef ID_EX_LOAD_USE_HAZARD_EN
    return m_valid && m_s.mem_to_reg && m_s.reg_write && (m_s.rt != 5'd0) &&
           ((m_s.rt == in_s.rs) || (m_s.rt == in_s.rt));
`else
    return 1'b0;
`endif
  endfunction

  // An empty stage holds a NOP: control bits and alu_op are zero, data fields keep old values.
  task automatic model_empty();
    m_valid         = 1'b0;
    m_s.alu_op      = '0;
    m_s.branch      = 1'b0;
    m_s.mem_write   = 1'b0;
    m_s.reg_write   = 1'b0;
    m_s.mem_to_reg  = 1'b0;
  endtask

  task automatic rand_in();
    in_s.alu_op     = 6'($urandom);
    in_s.reg_dst    = 1'($urandom);
    in_s.alu_src    = 1'($urandom);
    in_s.branch     = 1'($urandom);
    in_s.mem_write  = 1'($urandom);
    in_s.reg_write  = 1'($urandom);
    in_s.mem_to_reg = 1'($urandom);
    in_s.pc         = 7'($urandom);
    in_s.d1         = $urandom;
    in_s.d2         = $urandom;
    in_s.se         = $urandom;
    in_s.r1         = 5'($urandom);
    in_s.r2         = 5'($urandom);
    in_s.rs         = 5'($urandom_range(0, 3));
    in_s.rt         = 5'($urandom_range(0, 3));
  endtask

  // One clock: drive at negedge, check handshake, advance model at posedge, check state.
  task automatic step(input logic fl, input logic iv, input logic ordy);
    logic hz, rdy, ld;
    flush = fl;
    in_valid = iv;
    out_ready = ordy;
    #1;
    hz  = model_hazard();
    rdy = (!m_valid || ordy) && !hz;
    last_rdy = in_ready;
    last_hz = hazard_stall;
    chk("in_ready", 160'(in_ready), 160'(rdy));
    chk("hazard_stall", 160'(hazard_stall), 160'(hz));
    ld = iv && rdy;
    @(posedge clk);
    if (fl) model_empty();
    else if (ld) begin
      m_valid = 1'b1;
      m_s = in_s;
    end else if (m_valid && ordy) model_empty();
    if (!m_valid && m_bub < CntMax) m_bub++;
    #1;
    chk("out_valid", 160'(out_valid), 160'(m_valid));
    chk("regs", 160'(out_s), 160'(m_s));
    chk("bubble_cnt", 160'(bubble_cnt), 160'(m_bub));
    @(negedge clk);
  endtask

  initial begin
    int b;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_s = '0;
    m_s = '0;
    m_valid = 1'b0;
    m_bub = 0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 160'(out_valid), 160'(0));
    chk("reset_regs", 160'(out_s), 160'(0));
    chk("reset_bub", 160'(bubble_cnt), 160'(0));
    rst = 1'b0;

    // Streaming back-to-back.
    rand_in();
    in_s.mem_to_reg = 1'b0;
    in_s.d1 = 32'hDEADBEEF;
    step(1'b0, 1'b1, 1'b1);
    chk("stream_d1_a", 160'(data1_reg), 160'(32'hDEADBEEF));
    rand_in();
    in_s.mem_to_reg = 1'b0;
    in_s.d1 = 32'h12345678;
    step(1'b0, 1'b1, 1'b1);
    chk("stream_d1_b", 160'(data1_reg), 160'(32'h12345678));
    chk("stream_valid", 160'(out_valid), 160'(1));
    chk("stream_bub", 160'(bubble_cnt), 160'(0));

    // Stall: hold pc 0x15 while new instructions wait.
    rand_in();
    in_s.mem_to_reg = 1'b0;
    in_s.pc = 7'h15;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_in();
      in_s.mem_to_reg = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      chk("stall_pc", 160'(pc_next_reg), 160'(7'h15));
      chk("stall_rdy", 160'(last_rdy), 160'(0));
      chk("stall_valid", 160'(out_valid), 160'(1));
    end

    // Flush squashes a held store/writeback even with a new valid input.
    rand_in();
    in_s.mem_to_reg = 1'b0;
    in_s.reg_write = 1'b1;
    in_s.mem_write = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    b = m_bub;
    rand_in();
    step(1'b1, 1'b1, 1'b1);
    chk("flush_valid", 160'(out_valid), 160'(0));
    chk("flush_rw", 160'(reg_write_reg), 160'(0));
    chk("flush_mw", 160'(mem_write_reg), 160'(0));
    chk("flush_bub", 160'(bubble_cnt), 160'(b + 1));

    // Asynchronous reset in the middle of a hold.
    rand_in();
    in_s.mem_to_reg = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 160'(out_valid), 160'(0));
    chk("midrst_regs", 160'(out_s), 160'(0));
    chk("midrst_bub", 160'(bubble_cnt), 160'(0));
    m_s = '0;
    m_valid = 1'b0;
    m_bub = 0;
    @(negedge clk);
    rst = 1'b0;

    // Saturation of the 4-bit bubble counter.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    chk("sat_15", 160'(bubble_cnt), 160'(15));
    step(1'b0, 1'b0, 1'b0);
    chk("sat_hold", 160'(bubble_cnt), 160'(15));

`ifdef ID_EX_LOAD_USE_HAZARD_EN
    // Load with rt=5 followed by a consumer of r5: one bubble then the consumer loads.
    rand_in();
    in_s.mem_to_reg = 1'b1;
    in_s.reg_write = 1'b1;
    in_s.rt = 5'd5;
    in_s.rs = 5'd1;
    step(1'b0, 1'b1, 1'b1);
    rand_in();
    in_s.rs = 5'd5;
    in_s.rt = 5'd7;
    step(1'b0, 1'b1, 1'b1);
    chk("hz_stall", 160'(last_hz), 160'(1));
    chk("hz_rdy", 160'(last_rdy), 160'(0));
    chk("hz_bubble", 160'(out_valid), 160'(0));
    step(1'b0, 1'b1, 1'b1);
    chk("hz_load", 160'(out_valid), 160'(1));
    chk("hz_rs", 160'(rs_reg), 160'(5));
    // Load targeting r0 never stalls.
    rand_in();
    in_s.mem_to_reg = 1'b1;
    in_s.reg_write = 1'b1;
    in_s.rt = 5'd0;
    step(1'b0, 1'b1, 1'b1);
    rand_in();
    in_s.rs = 5'd0;
    in_s.rt = 5'd0;
    step(1'b0, 1'b1, 1'b1);
    chk("hz_r0", 160'(last_hz), 160'(0));
    chk("hz_r0_rdy", 160'(last_rdy), 160'(1));
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register with a valid/ready handshake, flush and bubble insertion.
- Sits between the decode stage (register file read, sign extend, control decode) and the execute stage (ALU, forwarding mux).
- Replaces the fixed-width, always-load ID/EX latch, so the pipeline can stall, squash after a taken branch, and count bubbles.

Parameters:
- DATA_W, 32, width of data1/data2/sign_extend.
- PC_W, 7, width of pc_next.
- RADDR_W, 5, width of register specifiers (reg1, reg2, rs, rt).
- ALUOP_W, 6, width of alu_op.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- flush  in  1  squash the held instruction (taken branch).
- out_ready  in  1  execute stage consumes the held instruction this cycle.
- out_valid  out  1  held instruction is valid.
- alu_op, reg_dst, alu_src, branch, mem_write, reg_write, mem_to_reg  in  ALUOP_W/1/1/1/1/1/1  decoded control.
- pc_next  in  PC_W  incremented PC.
- data1, data2, sign_extend  in  DATA_W each  operands.
- reg1, reg2, rs, rt  in  RADDR_W each  register specifiers.
- <each input above>_reg  out  same widths  registered copies.
- bubble_cnt  out  CNT_W  count of cycles with out_valid=0.
- hazard_stall  out  1  load-use stall indicator (see Optional Feature).

Behaviour:
- Reset (async assert, sync to clk on release): every output register = 0; out_valid=0; bubble_cnt=0.
- in_ready = !out_valid | out_ready (combinational). Gated further by the hazard logic when the Optional Feature is compiled in.
- Load = in_valid & in_ready. On load, all _reg outputs take the inputs at the next edge and out_valid=1. Latency is 1 cycle.
- Hold: out_valid=1 & out_ready=0 → all _reg outputs and out_valid are unchanged; in_ready=0.
- Drain: out_valid=1 & out_ready=1 & no load → out_valid=0 at the next edge.
  - Control outputs (reg_write_reg, mem_write_reg, branch_reg, mem_to_reg_reg) are cleared to 0 and alu_op_reg is cleared to 0.
  - Data and specifier outputs hold their previous values.
- Flush has top priority. With flush=1 at an edge:
  - out_valid=0 and the control outputs listed above are cleared, regardless of in_valid, out_ready or hold.
  - Data fields are don't-care; the implementation leaves them unchanged.
- Invariant: whenever out_valid=0, reg_write_reg=mem_write_reg=branch_reg=mem_to_reg_reg=0. This makes a bubble architecturally a NOP.
- bubble_cnt increments on each edge where the post-edge out_valid is 0. It saturates at 2^CNT_W-1 (no wrap) and is cleared only by rst.
- Simultaneous drain and load: the new instruction is captured and out_valid stays 1 (back-to-back throughput of 1 per cycle).
- Reset asserted mid-hold clears everything immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ID_EX_LOAD_USE_HAZARD_EN.
- With the macro defined, a load-use hazard is detected when all of the following hold:
  - out_valid=1, mem_to_reg_reg=1 and reg_write_reg=1;
  - rt_reg != 0;
  - rt_reg == rs or rt_reg == rt (the incoming specifiers).
- On a detected hazard:
  - hazard_stall=1 and in_ready is forced to 0.
  - If out_ready=1, the stage drains and inserts a bubble on the next edge; decode holds its instruction and retries.
  - Flush still has priority over the hazard.
- Without the macro: hazard_stall is tied to 0 and in_ready follows the base rule only.

Test Plan:
1. Reset: rst=1 mid-cycle with out_valid=1 → all outputs 0 immediately; bubble_cnt=0.
2. Streaming: in_valid=1, out_ready=1, data1=0xDEADBEEF then 0x12345678 on consecutive cycles → data1_reg shows each value one cycle later; out_valid stays 1; bubble_cnt does not increment.
3. Stall: load pc_next=7'h15, then out_ready=0 for 3 cycles with new inputs presented → pc_next_reg stays 0x15, in_ready=0, out_valid=1 throughout.
4. Flush: held reg_write=1, mem_write=1; flush=1 with in_valid=1 → next cycle out_valid=0, reg_write_reg=0, mem_write_reg=0, bubble_cnt increments by 1.
5. Saturation: CNT_W=4, idle 20 cycles after reset → bubble_cnt=15 and stays 15.
6. With ID_EX_LOAD_USE_HAZARD_EN: held load with rt_reg=5, mem_to_reg_reg=1; incoming rs=5 → hazard_stall=1, in_ready=0, one bubble inserted, then the instruction loads; with rt_reg=0 → no stall.
